// File: rtl/dram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_responder_pkg
// Purpose  : Shared widths and limits for the core DRAM responder.
// Revision : 1.0 - initial release
// ============================================================================
package dram_responder_pkg;

    localparam int DATA_W      = 8;
    localparam int CORE_ADDR_W = 16;
    localparam int COLL_CNT_W  = 8;
    localparam logic [COLL_CNT_W-1:0] COLL_CNT_MAX = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/dram_write_select.sv
`default_nettype none
// ============================================================================
// Module   : dram_write_select
// Purpose  : Per-address write arbitration across cores; lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module dram_write_select
    import dram_responder_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12
) (
    input  logic [CORE_ADDR_W*NUM_CORES-1:0] i_addr,
    input  logic [NUM_CORES-1:0]             i_write,
    input  logic                             i_block,
    output logic [NUM_CORES-1:0]             o_write_en,
    output logic                             o_collision
);

    logic [NUM_CORES-1:0] w_valid;

    // Only in-range, unblocked writes take part; any loser means a collision.
    always_comb begin
        w_valid    = '0;
        o_write_en = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_valid[k] = i_write[k] && !i_block &&
                (i_addr[CORE_ADDR_W*k+ADDR_W +: CORE_ADDR_W-ADDR_W] == '0);
        end
        for (int k = 0; k < NUM_CORES; k++) begin
            o_write_en[k] = w_valid[k];
            for (int j = 0; j < k; j++) begin
                if (w_valid[j] &&
                    (i_addr[CORE_ADDR_W*j +: CORE_ADDR_W] == i_addr[CORE_ADDR_W*k +: CORE_ADDR_W])) begin
                    o_write_en[k] = 1'b0;
                end
            end
        end
    end

    assign o_collision = |(w_valid & ~o_write_en);

endmodule
`default_nettype wire

// File: rtl/dram_responder.sv
`default_nettype none
// ============================================================================
// Module   : dram_responder
// Purpose  : Shared byte memory serving NUM_CORES core ports plus a host port.
// Revision : 1.0 - initial release
// ============================================================================
module dram_responder
    import dram_responder_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [CORE_ADDR_W*NUM_CORES-1:0] i_dram_addr,
    input  logic [NUM_CORES-1:0]             i_dram_read,
    input  logic [NUM_CORES-1:0]             i_dram_write,
    input  logic [DATA_W*NUM_CORES-1:0]      i_dram_in,
    output logic [DATA_W*NUM_CORES-1:0]      o_dram_out,
    input  logic                             i_host_en,
    input  logic                             i_host_we,
    input  logic [CORE_ADDR_W-1:0]           i_host_addr,
    input  logic [DATA_W-1:0]                i_host_data,
    output logic [DATA_W-1:0]                o_host_data,
    output logic                             o_host_valid,
    output logic [COLL_CNT_W-1:0]            o_collision_cnt,
    output logic                             o_oob_err
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]           r_mem [DEPTH];
    logic [DATA_W*NUM_CORES-1:0] r_dram_out;
    logic [DATA_W-1:0]           r_host_data;
    logic                        r_host_valid;
    logic [COLL_CNT_W-1:0]       r_coll_cnt;
    logic                        r_oob_err;

    logic [NUM_CORES-1:0] w_core_oob;
    logic [NUM_CORES-1:0] w_write_en;
    logic                 w_collision;
    logic                 w_host_oob;
    logic                 w_any_oob;
    logic [ADDR_W-1:0]    w_host_idx;

    always_comb begin
        w_core_oob = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_core_oob[k] = (i_dram_addr[CORE_ADDR_W*k+ADDR_W +: CORE_ADDR_W-ADDR_W] != '0);
        end
    end

    assign w_host_oob = (i_host_addr[CORE_ADDR_W-1:ADDR_W] != '0);
    assign w_host_idx = i_host_addr[ADDR_W-1:0];
    // Core strobes blocked by the host never count as out-of-range accesses.
    assign w_any_oob  = i_host_en ? w_host_oob
                                  : |((i_dram_read | i_dram_write) & w_core_oob);

    dram_write_select #(
        .NUM_CORES (NUM_CORES),
        .ADDR_W    (ADDR_W)
    ) u_write_select (
        .i_addr      (i_dram_addr),
        .i_write     (i_dram_write),
        .i_block     (i_host_en),
        .o_write_en  (w_write_en),
        .o_collision (w_collision)
    );

    // The array has no reset, but writes are suppressed while reset is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dram_out   <= '0;
            r_host_data  <= '0;
            r_host_valid <= 1'b0;
            r_coll_cnt   <= '0;
            r_oob_err    <= 1'b0;
        end else begin
            r_host_valid <= i_host_en && !i_host_we;
            if (w_any_oob) begin
                r_oob_err <= 1'b1;
            end
            if (i_host_en) begin
                if (i_host_we) begin
                    if (!w_host_oob) begin
                        r_mem[w_host_idx] <= i_host_data;
                    end
                end else begin
                    r_host_data <= w_host_oob ? '0 : r_mem[w_host_idx];
                end
            end else begin
                for (int k = 0; k < NUM_CORES; k++) begin
                    if (i_dram_read[k]) begin
                        r_dram_out[DATA_W*k +: DATA_W] <= w_core_oob[k] ? '0
                            : r_mem[i_dram_addr[CORE_ADDR_W*k +: ADDR_W]];
                    end
                    if (w_write_en[k]) begin
                        r_mem[i_dram_addr[CORE_ADDR_W*k +: ADDR_W]] <= i_dram_in[DATA_W*k +: DATA_W];
                    end
                end
                if (w_collision && (r_coll_cnt != COLL_CNT_MAX)) begin
                    r_coll_cnt <= r_coll_cnt + 1'b1;
                end
            end
        end
    end

    assign o_dram_out      = r_dram_out;
    assign o_host_data     = r_host_data;
    assign o_host_valid    = r_host_valid;
    assign o_collision_cnt = r_coll_cnt;
    assign o_oob_err       = r_oob_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_responder
// Purpose  : Directed and randomized checks of dram_responder against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_responder;

    localparam int NC    = 4;
    localparam int DEPTH = 4096;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b1;
    logic [16*NC-1:0] i_dram_addr = '0;
    logic [NC-1:0]   i_dram_read = '0;
    logic [NC-1:0]   i_dram_write = '0;
    logic [8*NC-1:0] i_dram_in = '0;
    logic [8*NC-1:0] o_dram_out;
    logic            i_host_en = 1'b0;
    logic            i_host_we = 1'b0;
    logic [15:0]     i_host_addr = '0;
    logic [7:0]      i_host_data = '0;
    logic [7:0]      o_host_data;
    logic            o_host_valid;
    logic [7:0]      o_collision_cnt;
    logic            o_oob_err;

    dram_responder #(.NUM_CORES(NC), .ADDR_W(12)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_dram_addr     (i_dram_addr),
        .i_dram_read     (i_dram_read),
        .i_dram_write    (i_dram_write),
        .i_dram_in       (i_dram_in),
        .o_dram_out      (o_dram_out),
        .i_host_en       (i_host_en),
        .i_host_we       (i_host_we),
        .i_host_addr     (i_host_addr),
        .i_host_data     (i_host_data),
        .o_host_data     (o_host_data),
        .o_host_valid    (o_host_valid),
        .o_collision_cnt (o_collision_cnt),
        .o_oob_err       (o_oob_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Per-core request for the next cycle.
    logic [15:0] c_addr [NC];
    logic [7:0]  c_din  [NC];
    bit          c_rd   [NC];
    bit          c_wr   [NC];

    // Reference model state.
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_out [NC];
    logic [7:0] m_hdata = '0;
    bit         m_hvalid = 0;
    int         m_cnt = 0;
    bit         m_oob = 0;

    task automatic clear_core();
        for (int k = 0; k < NC; k++) begin
            c_addr[k] = '0; c_din[k] = '0; c_rd[k] = 0; c_wr[k] = 0;
        end
    endtask

    task automatic drive(input bit h_en, input bit h_we, input logic [15:0] h_addr, input logic [7:0] h_data);
        i_host_en = h_en; i_host_we = h_we; i_host_addr = h_addr; i_host_data = h_data;
        for (int k = 0; k < NC; k++) begin
            i_dram_addr[16*k +: 16] = c_addr[k];
            i_dram_in[8*k +: 8]     = c_din[k];
            i_dram_read[k]          = c_rd[k];
            i_dram_write[k]         = c_wr[k];
        end
    endtask

    function automatic bit in_range(input logic [15:0] a);
        return a < DEPTH;
    endfunction

    // Apply one cycle of requests to both DUT and model; returns #1 after the edge.
    task automatic step(input bit h_en, input bit h_we, input logic [15:0] h_addr, input logic [7:0] h_data);
        bit coll;
        drive(h_en, h_we, h_addr, h_data);
        m_hvalid = 0;
        if (h_en) begin
            if (!in_range(h_addr)) m_oob = 1;
            if (h_we) begin
                if (in_range(h_addr)) m_mem[h_addr[11:0]] = h_data;
            end else begin
                m_hvalid = 1;
                m_hdata  = in_range(h_addr) ? m_mem[h_addr[11:0]] : 8'h00;
            end
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (c_rd[k]) begin
                    if (in_range(c_addr[k])) m_out[k] = m_mem[c_addr[k][11:0]];
                    else begin m_out[k] = 8'h00; m_oob = 1; end
                end
                if (c_wr[k] && !in_range(c_addr[k])) m_oob = 1;
            end
            coll = 0;
            for (int k = 0; k < NC; k++)
                for (int j = 0; j < k; j++)
                    if (c_wr[j] && c_wr[k] && in_range(c_addr[k]) && c_addr[j] == c_addr[k]) coll = 1;
            // Highest index first so the lowest index lands last and wins.
            for (int k = NC-1; k >= 0; k--)
                if (c_wr[k] && in_range(c_addr[k])) m_mem[c_addr[k][11:0]] = c_din[k];
            if (coll && m_cnt < 255) m_cnt++;
        end
        @(posedge i_clk); #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) m_out[k] = '0;
        m_hdata = '0; m_hvalid = 0; m_cnt = 0; m_oob = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        total++; if (o_dram_out !== '0) begin bad++; $display("FAIL %s dram_out: got %h want 0", tag, o_dram_out); end
        total++; if (o_host_data !== 8'h00) begin bad++; $display("FAIL %s host_data: got %h want 0", tag, o_host_data); end
        total++; if (o_host_valid !== 1'b0) begin bad++; $display("FAIL %s host_valid: got %b want 0", tag, o_host_valid); end
        total++; if (o_collision_cnt !== 8'h00) begin bad++; $display("FAIL %s coll_cnt: got %h want 0", tag, o_collision_cnt); end
        total++; if (o_oob_err !== 1'b0) begin bad++; $display("FAIL %s oob_err: got %b want 0", tag, o_oob_err); end
    endtask

    task automatic test_reset();
        clear_core();
        drive(0, 0, '0, '0);
        #3 i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_zero_outputs("reset");
        i_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_host();
        clear_core();
        step(1, 1, 16'h0005, 8'h10);
        total++; if (o_host_valid !== 1'b0) begin bad++; $display("FAIL host_wr_valid: got %b want 0", o_host_valid); end
        step(1, 0, 16'h0005, 8'h00);
        total++; if (o_host_data !== 8'h10) begin bad++; $display("FAIL host_rd_data: got %h want 10", o_host_data); end
        total++; if (o_host_valid !== 1'b1) begin bad++; $display("FAIL host_rd_valid: got %b want 1", o_host_valid); end
        step(0, 0, '0, '0);
        total++; if (o_host_valid !== 1'b0) begin bad++; $display("FAIL host_valid_pulse: got %b want 0", o_host_valid); end
        total++; if (o_host_data !== 8'h10) begin bad++; $display("FAIL host_data_hold: got %h want 10", o_host_data); end
    endtask

    task automatic test_read_first();
        clear_core();
        c_addr[0] = 16'h0005; c_rd[0] = 1;
        c_addr[1] = 16'h0005; c_wr[1] = 1; c_din[1] = 8'h77;
        step(0, 0, '0, '0);
        total++; if (o_dram_out[7:0] !== 8'h10) begin bad++; $display("FAIL read_first_old: got %h want 10", o_dram_out[7:0]); end
        clear_core();
        c_addr[0] = 16'h0005; c_rd[0] = 1;
        step(0, 0, '0, '0);
        total++; if (o_dram_out[7:0] !== 8'h77) begin bad++; $display("FAIL read_first_new: got %h want 77", o_dram_out[7:0]); end
        clear_core();
        step(0, 0, '0, '0);
        total++; if (o_dram_out[7:0] !== 8'h77) begin bad++; $display("FAIL read_hold: got %h want 77", o_dram_out[7:0]); end
    endtask

    task automatic test_host_priority();
        clear_core();
        step(1, 1, 16'h0030, 8'h99);
        c_addr[0] = 16'h0030; c_wr[0] = 1; c_rd[0] = 1; c_din[0] = 8'h55;
        c_addr[1] = 16'h0031; c_wr[1] = 1; c_din[1] = 8'h01;
        c_addr[2] = 16'h0031; c_wr[2] = 1; c_din[2] = 8'h02;
        step(1, 0, 16'h0030, 8'h00);
        total++; if (o_dram_out[7:0] !== 8'h77) begin bad++; $display("FAIL prio_out_hold: got %h want 77", o_dram_out[7:0]); end
        total++; if (o_host_data !== 8'h99) begin bad++; $display("FAIL prio_host_rd: got %h want 99", o_host_data); end
        total++; if (o_collision_cnt !== 8'h00) begin bad++; $display("FAIL prio_no_coll: got %h want 0", o_collision_cnt); end
        clear_core();
        step(1, 0, 16'h0030, 8'h00);
        total++; if (o_host_data !== 8'h99) begin bad++; $display("FAIL prio_mem_kept: got %h want 99", o_host_data); end
    endtask

    task automatic test_collision();
        clear_core();
        for (int k = 1; k < NC; k++) begin
            c_addr[k] = 16'h0020; c_wr[k] = 1; c_din[k] = 8'hA0 + 8'(k);
        end
        step(0, 0, '0, '0);
        total++; if (o_collision_cnt !== 8'h01) begin bad++; $display("FAIL coll_cnt_one: got %h want 01", o_collision_cnt); end
        clear_core();
        step(1, 0, 16'h0020, 8'h00);
        total++; if (o_host_data !== 8'hA1) begin bad++; $display("FAIL coll_winner: got %h want a1", o_host_data); end
        for (int k = 1; k < NC; k++) begin
            c_addr[k] = 16'h0020; c_wr[k] = 1; c_din[k] = 8'hA0 + 8'(k);
        end
        for (int i = 0; i < 300; i++) step(0, 0, '0, '0);
        total++; if (o_collision_cnt !== 8'hFF) begin bad++; $display("FAIL coll_saturate: got %h want ff", o_collision_cnt); end
        clear_core();
    endtask

    task automatic test_oob();
        clear_core();
        total++; if (o_oob_err !== 1'b0) begin bad++; $display("FAIL oob_initial: got %b want 0", o_oob_err); end
        step(1, 1, 16'h0000, 8'h3C);
        c_addr[2] = 16'h0020; c_rd[2] = 1;
        step(0, 0, '0, '0);
        total++; if (o_dram_out[23:16] !== 8'hA1) begin bad++; $display("FAIL oob_pre_read: got %h want a1", o_dram_out[23:16]); end
        total++; if (o_oob_err !== 1'b0) begin bad++; $display("FAIL oob_still_clear: got %b want 0", o_oob_err); end
        clear_core();
        c_addr[2] = 16'h1000; c_wr[2] = 1; c_din[2] = 8'hEE;
        step(0, 0, '0, '0);
        total++; if (o_oob_err !== 1'b1) begin bad++; $display("FAIL oob_set: got %b want 1", o_oob_err); end
        clear_core();
        step(1, 0, 16'h0000, 8'h00);
        total++; if (o_host_data !== 8'h3C) begin bad++; $display("FAIL oob_no_alias: got %h want 3c", o_host_data); end
        c_addr[2] = 16'h1000; c_rd[2] = 1;
        step(0, 0, '0, '0);
        total++; if (o_dram_out[23:16] !== 8'h00) begin bad++; $display("FAIL oob_read_zero: got %h want 00", o_dram_out[23:16]); end
        clear_core();
        repeat (3) step(0, 0, '0, '0);
        total++; if (o_oob_err !== 1'b1) begin bad++; $display("FAIL oob_sticky: got %b want 1", o_oob_err); end
    endtask

    task automatic test_reset_preserve();
        clear_core();
        c_addr[0] = 16'h0005; c_rd[0] = 1;
        step(0, 0, '0, '0);
        i_rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        c_addr[0] = 16'h0005; c_wr[0] = 1; c_rd[0] = 0; c_din[0] = 8'hBB;
        drive(0, 0, '0, '0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        model_reset();
        clear_core();
        step(1, 0, 16'h0005, 8'h00);
        total++; if (o_host_data !== 8'h77) begin bad++; $display("FAIL mem_preserved: got %h want 77", o_host_data); end
        total++; if (o_oob_err !== 1'b0) begin bad++; $display("FAIL oob_cleared: got %b want 0", o_oob_err); end
    endtask

    task automatic test_random();
        logic [15:0] ha;
        bit he, hw;
        clear_core();
        for (int a = 0; a < 8; a++) step(1, 1, 16'h0100 + 16'(a), 8'($urandom));
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NC; k++) begin
                c_addr[k] = ($urandom_range(0, 24) == 0) ? 16'h1000 + 16'($urandom_range(0, 16'hEFFF))
                                                        : 16'h0100 + 16'($urandom_range(0, 7));
                c_rd[k]  = bit'($urandom_range(0, 1));
                c_wr[k]  = ($urandom_range(0, 2) == 0);
                c_din[k] = 8'($urandom);
            end
            he = ($urandom_range(0, 7) == 0);
            hw = bit'($urandom_range(0, 1));
            ha = ($urandom_range(0, 15) == 0) ? 16'hF000 : 16'h0100 + 16'($urandom_range(0, 7));
            step(he, hw, ha, 8'($urandom));
            for (int k = 0; k < NC; k++) begin
                total++;
                if (o_dram_out[8*k +: 8] !== m_out[k]) begin
                    bad++; $display("FAIL rand_out[%0d] cyc %0d: got %h want %h", k, i, o_dram_out[8*k +: 8], m_out[k]);
                end
            end
            total++; if (o_collision_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL rand_coll cyc %0d: got %0d want %0d", i, o_collision_cnt, m_cnt); end
            total++; if (o_oob_err !== m_oob) begin bad++; $display("FAIL rand_oob cyc %0d: got %b want %b", i, o_oob_err, m_oob); end
            total++; if (o_host_valid !== m_hvalid) begin bad++; $display("FAIL rand_hvalid cyc %0d: got %b want %b", i, o_host_valid, m_hvalid); end
            total++; if (o_host_data !== m_hdata) begin bad++; $display("FAIL rand_hdata cyc %0d: got %h want %h", i, o_host_data, m_hdata); end
        end
    endtask

    initial begin
        test_reset();
        test_host();
        test_read_first();
        test_host_priority();
        test_collision();
        test_oob();
        test_reset_preserve();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
